// File: rtl/cache_arbiter_pkg.sv
// Shared types and widths for the cache-to-memory arbiter and the caches it serves.
package cache_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        CACHE_IDLE      = 2'd0,
        CACHE_COMPARE   = 2'd1,
        CACHE_WRITEBACK = 2'd2,
        CACHE_ALLOCATE  = 2'd3
    } cache_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              read;
        logic              write;
        logic [LINE_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cacheline memory port between the I-cache and D-cache.
// One transaction outstanding; the granted requester's bus is passed straight through.
module cache_arbiter
    import cache_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t r_state;
    requester_t r_last_served;

    logic     w_i_pending;
    logic     w_d_pending;
    mem_req_t w_i_req;
    mem_req_t w_d_req;
    mem_req_t w_mem_req;

    // On a tie the requester not served last wins.
    function automatic arb_state_t grant_sel(
        input logic       req_i,
        input logic       req_d,
        input requester_t last
    );
        arb_state_t sel;
        sel = IDLE;
        if (req_i && req_d) begin
            sel = (last == REQ_I) ? SERVE_D : SERVE_I;
        end else if (req_i) begin
            sel = SERVE_I;
        end else if (req_d) begin
            sel = SERVE_D;
        end
        return sel;
    endfunction

    assign w_i_pending = i_read | i_write;
    assign w_d_pending = d_read | d_write;

    assign w_i_req = '{addr: i_addr, read: i_read, write: i_write, wdata: i_wdata};
    assign w_d_req = '{addr: d_addr, read: d_read, write: d_write, wdata: d_wdata};

    // A dropped request mid-service is not recovered: we leave SERVE_x only on mem_resp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_last_served <= REQ_I;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= grant_sel(w_i_pending, w_d_pending, r_last_served);
                end
                SERVE_I: begin
                    if (mem_resp) begin
                        r_state       <= IDLE;
                        r_last_served <= REQ_I;
                    end
                end
                SERVE_D: begin
                    if (mem_resp) begin
                        r_state       <= IDLE;
                        r_last_served <= REQ_D;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Pass-through datapath; everything idles at zero, so reset clears outputs without a clock.
    always_comb begin
        w_mem_req = '0;
        i_resp    = 1'b0;
        d_resp    = 1'b0;
        i_rdata   = '0;
        d_rdata   = '0;
        case (r_state)
            SERVE_I: begin
                w_mem_req = w_i_req;
                i_resp    = mem_resp;
                i_rdata   = mem_rdata;
            end
            SERVE_D: begin
                w_mem_req = w_d_req;
                d_resp    = mem_resp;
                d_rdata   = mem_rdata;
            end
            default: begin
                w_mem_req = '0;
            end
        endcase
    end

    assign mem_addr  = w_mem_req.addr;
    assign mem_read  = w_mem_req.read;
    assign mem_write = w_mem_req.write;
    assign mem_wdata = w_mem_req.wdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus a randomized run
// against a transaction-level model with a 1-5 cycle memory latency.
module tb_cache_arbiter;

    logic         clk;
    logic         rst_n;
    logic [31:0]  i_addr, d_addr, mem_addr;
    logic         i_read, i_write, d_read, d_write;
    logic [255:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic         i_resp, d_resp, mem_read, mem_write, mem_resp;

    int n_checks = 0;
    int n_pass   = 0;

    cache_arbiter u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_addr    (i_addr),
        .i_read    (i_read),
        .i_write   (i_write),
        .i_wdata   (i_wdata),
        .i_rdata   (i_rdata),
        .i_resp    (i_resp),
        .d_addr    (d_addr),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_resp    (d_resp),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_resp  (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simultaneous read and write is forwarded as-is by the arbiter; flag it here.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(i_read && i_write)) else $error("I port drives read and write together");
            assert (!(d_read && d_write)) else $error("D port drives read and write together");
        end
    end

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic clear_inputs();
        i_addr = '0; i_read = 1'b0; i_write = 1'b0; i_wdata = '0;
        d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
        mem_rdata = '0; mem_resp = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        i_read = 1'b1; i_addr = 32'h0000_0100;
        d_write = 1'b1; d_addr = 32'h0000_0200; d_wdata = {8{32'hDEAD_BEEF}};
        mem_resp = 1'b1; mem_rdata = {8{32'h1234_5678}};
        #1;
        n_checks++;
        if ({mem_addr, mem_read, mem_write, mem_wdata, i_resp, d_resp} !== '0)
            $display("FAIL reset_outputs: addr=%h rd=%b wr=%b resp_i=%b resp_d=%b, required all 0",
                     mem_addr, mem_read, mem_write, i_resp, d_resp);
        else n_pass++;
        apply_reset();
        @(posedge clk); #1;
        n_checks++;
        if ({mem_read, mem_write, mem_addr} !== '0)
            $display("FAIL reset_idle: rd=%b wr=%b addr=%h, required 0", mem_read, mem_write, mem_addr);
        else n_pass++;
    endtask

    task automatic test_single_i();
        apply_reset();
        @(posedge clk); #1;
        i_read = 1'b1; i_addr = 32'h0000_0040;
        @(negedge clk);
        n_checks++;
        if (mem_read !== 1'b0) $display("FAIL single_i_grant_cycle: mem_read=%b, required 0", mem_read);
        else n_pass++;
        @(posedge clk); #1;
        mem_resp = 1'b1; mem_rdata = {32{8'hAA}};
        @(negedge clk);
        n_checks++;
        if ({mem_read, mem_write, mem_addr} !== {1'b1, 1'b0, 32'h0000_0040})
            $display("FAIL single_i_mem: rd=%b wr=%b addr=%h, required 1 0 00000040", mem_read, mem_write, mem_addr);
        else n_pass++;
        n_checks++;
        if ({i_resp, d_resp, i_rdata, d_rdata} !== {1'b1, 1'b0, {32{8'hAA}}, 256'd0})
            $display("FAIL single_i_resp: i_resp=%b d_resp=%b i_rdata=%h d_rdata=%h, required 1 0 aa..aa 0",
                     i_resp, d_resp, i_rdata, d_rdata);
        else n_pass++;
        @(posedge clk); #1;
        i_read = 1'b0; mem_resp = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_read, i_resp} !== 2'b00) $display("FAIL single_i_done: rd=%b i_resp=%b, required 0 0", mem_read, i_resp);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic         exp_d;
        logic [255:0] data;
        apply_reset();
        @(posedge clk); #1;
        i_read = 1'b1; i_addr = 32'h0000_1000;
        d_read = 1'b1; d_addr = 32'h0000_2000;
        exp_d = 1'b1;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            n_checks++;
            if (mem_read !== 1'b0) $display("FAIL rr_idle_gap round %0d: mem_read=%b, required 0", r, mem_read);
            else n_pass++;
            @(posedge clk); #1;
            data = rand_line();
            mem_resp = 1'b1; mem_rdata = data;
            @(negedge clk);
            n_checks++;
            if ({mem_addr, i_resp, d_resp} !== {(exp_d ? 32'h0000_2000 : 32'h0000_1000), ~exp_d, exp_d})
                $display("FAIL rr_order round %0d: addr=%h i_resp=%b d_resp=%b, required served %s",
                         r, mem_addr, i_resp, d_resp, exp_d ? "D" : "I");
            else n_pass++;
            n_checks++;
            if ((exp_d ? d_rdata : i_rdata) !== data || (exp_d ? i_rdata : d_rdata) !== 256'd0)
                $display("FAIL rr_rdata round %0d: i_rdata=%h d_rdata=%h, required served=%h other=0",
                         r, i_rdata, d_rdata, data);
            else n_pass++;
            @(posedge clk); #1;
            mem_resp = 1'b0;
            exp_d = ~exp_d;
        end
        clear_inputs();
    endtask

    task automatic test_writeback_allocate();
        apply_reset();
        @(posedge clk); #1;
        d_write = 1'b1; d_addr = 32'h1000_0020; d_wdata = {32{8'h55}};
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if ({mem_write, mem_read, mem_addr, mem_wdata} !== {1'b1, 1'b0, 32'h1000_0020, {32{8'h55}}})
            $display("FAIL wb_mem: wr=%b rd=%b addr=%h wdata=%h, required 1 0 10000020 55..55",
                     mem_write, mem_read, mem_addr, mem_wdata);
        else n_pass++;
        @(posedge clk); #1;
        mem_resp = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({d_resp, i_resp} !== 2'b10) $display("FAIL wb_resp: d_resp=%b i_resp=%b, required 1 0", d_resp, i_resp);
        else n_pass++;
        @(posedge clk); #1;
        mem_resp = 1'b0;
        d_write = 1'b0; d_read = 1'b1; d_wdata = '0;
        i_read = 1'b1; i_addr = 32'h0000_0200;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if ({mem_read, mem_addr} !== {1'b1, 32'h0000_0200})
            $display("FAIL wb_i_between: rd=%b addr=%h, required 1 00000200", mem_read, mem_addr);
        else n_pass++;
        @(posedge clk); #1;
        mem_resp = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({i_resp, d_resp} !== 2'b10) $display("FAIL wb_i_resp: i_resp=%b d_resp=%b, required 1 0", i_resp, d_resp);
        else n_pass++;
        @(posedge clk); #1;
        mem_resp = 1'b0; i_read = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if ({mem_read, mem_write, mem_addr} !== {1'b1, 1'b0, 32'h1000_0020})
            $display("FAIL wb_allocate: rd=%b wr=%b addr=%h, required 1 0 10000020", mem_read, mem_write, mem_addr);
        else n_pass++;
        @(posedge clk); #1;
        mem_resp = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({d_resp, i_resp} !== 2'b10) $display("FAIL wb_alloc_resp: d_resp=%b i_resp=%b, required 1 0", d_resp, i_resp);
        else n_pass++;
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        @(posedge clk); #1;
        i_read = 1'b1; i_addr = 32'h0000_0380;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (mem_read !== 1'b1) $display("FAIL mid_reset_pre: mem_read=%b, required 1", mem_read);
        else n_pass++;
        #2;
        mem_resp = 1'b1; mem_rdata = {8{32'hCAFE_F00D}};
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_read, mem_write, mem_addr, mem_wdata, i_resp, d_resp} !== '0)
            $display("FAIL mid_reset_async: rd=%b addr=%h i_resp=%b d_resp=%b, required all 0",
                     mem_read, mem_addr, i_resp, d_resp);
        else n_pass++;
        i_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_checks++;
            if ({i_resp, d_resp, mem_read} !== 3'b000)
                $display("FAIL mid_reset_late_resp cycle %0d: i_resp=%b d_resp=%b rd=%b, required 0 0 0",
                         c, i_resp, d_resp, mem_read);
            else n_pass++;
        end
        clear_inputs();
    endtask

    task automatic test_spurious_resp();
        apply_reset();
        @(posedge clk); #1;
        mem_resp = 1'b1; mem_rdata = {8{32'h0BAD_0BAD}};
        @(negedge clk);
        n_checks++;
        if ({i_resp, d_resp, i_rdata, d_rdata, mem_read} !== '0)
            $display("FAIL spurious_resp: i_resp=%b d_resp=%b i_rdata=%h, required all 0", i_resp, d_resp, i_rdata);
        else n_pass++;
        @(posedge clk); #1;
        mem_resp = 1'b0;
        i_read = 1'b1; i_addr = 32'h0000_0A00;
        d_read = 1'b1; d_addr = 32'h0000_0B00;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if ({mem_read, mem_addr} !== {1'b1, 32'h0000_0B00})
            $display("FAIL spurious_state: rd=%b addr=%h, required 1 00000b00 (D first)", mem_read, mem_addr);
        else n_pass++;
        @(posedge clk); #1;
        clear_inputs();
        mem_resp = 1'b1;
        @(posedge clk); #1;
        mem_resp = 1'b0;
    endtask

    task automatic test_random();
        int           done = 0;
        int           cycles = 0;
        logic         ip = 1'b0, dp = 1'b0;
        int           iw = 0, dw = 0;
        logic         busy = 1'b0, who = 1'b0, last = 1'b0, resp_drv = 1'b0;
        int           lat = 0;
        logic [255:0] exp_data = '0;
        logic [31:0]  exp_addr;
        logic         exp_rd, exp_wr;
        logic [255:0] exp_wd;
        apply_reset();
        while (done < 1000 && cycles < 30000) begin
            @(posedge clk);
            cycles++;
            // Model: retire on resp, else grant one pending requester (tie goes to the one not served last).
            if (busy && resp_drv) begin
                busy = 1'b0; last = who; done++;
                n_checks++;
                if ((who ? dw : iw) > 1)
                    $display("FAIL rand_starvation txn %0d: %s waited %0d other txns, required <= 1",
                             done, who ? "D" : "I", who ? dw : iw);
                else n_pass++;
                if (who) begin dp = 1'b0; if (ip) iw++; end
                else     begin ip = 1'b0; if (dp) dw++; end
            end else if (!busy && (ip || dp)) begin
                who  = (ip && dp) ? ~last : dp;
                busy = 1'b1;
                lat  = $urandom_range(1, 5);
            end
            #1;
            resp_drv = 1'b0; mem_resp = 1'b0; mem_rdata = rand_line();
            if (busy) begin
                if (lat == 1) begin
                    resp_drv = 1'b1; exp_data = rand_line();
                    mem_resp = 1'b1; mem_rdata = exp_data;
                end else lat--;
            end
            if (!ip && $urandom_range(0, 1) == 1) begin
                ip = 1'b1; iw = 0;
                i_addr = $urandom; i_wdata = rand_line();
                i_read = ($urandom_range(0, 1) == 1); i_write = ~i_read;
            end
            if (!ip) begin i_read = 1'b0; i_write = 1'b0; end
            if (!dp && $urandom_range(0, 1) == 1) begin
                dp = 1'b1; dw = 0;
                d_addr = $urandom; d_wdata = rand_line();
                d_read = ($urandom_range(0, 1) == 1); d_write = ~d_read;
            end
            if (!dp) begin d_read = 1'b0; d_write = 1'b0; end
            @(negedge clk);
            exp_addr = busy ? (who ? d_addr : i_addr) : 32'd0;
            exp_rd   = busy ? (who ? d_read : i_read) : 1'b0;
            exp_wr   = busy ? (who ? d_write : i_write) : 1'b0;
            exp_wd   = busy ? (who ? d_wdata : i_wdata) : 256'd0;
            n_checks++;
            if ({mem_addr, mem_read, mem_write, mem_wdata} !== {exp_addr, exp_rd, exp_wr, exp_wd})
                $display("FAIL rand_mem cycle %0d: addr=%h rd=%b wr=%b, required addr=%h rd=%b wr=%b",
                         cycles, mem_addr, mem_read, mem_write, exp_addr, exp_rd, exp_wr);
            else n_pass++;
            n_checks++;
            if ({i_resp, d_resp} !== {resp_drv && !who, resp_drv && who})
                $display("FAIL rand_resp cycle %0d: i_resp=%b d_resp=%b, required %b %b",
                         cycles, i_resp, d_resp, resp_drv && !who, resp_drv && who);
            else n_pass++;
            if (resp_drv) begin
                n_checks++;
                if ((who ? d_rdata : i_rdata) !== exp_data || (who ? i_rdata : d_rdata) !== 256'd0)
                    $display("FAIL rand_rdata cycle %0d: i_rdata=%h d_rdata=%h, required served=%h other=0",
                             cycles, i_rdata, d_rdata, exp_data);
                else n_pass++;
            end
        end
        n_checks++;
        if (done < 1000) $display("FAIL rand_timeout: completed %0d txns, required 1000", done);
        else n_pass++;
        @(posedge clk); #1;
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b1;
        clear_inputs();
        test_reset();
        test_single_i();
        test_round_robin();
        test_writeback_allocate();
        test_reset_mid();
        test_spurious_resp();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
